// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared definitions for the UART-to-register-file command sequencer:
// state encoding, command opcodes and the default widths used by the register file and UART.
package reg_cmd_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [7:0] WR_CMD_DEF = 8'hAA;
  localparam logic [7:0] RD_CMD_DEF = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_t;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Command sequencer: turns UART RX byte frames into register-file writes/reads
// and returns read data to UART TX. Sole master of the register-file port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an opcode byte
// WR_ADDR | write opcode seen, waiting for the address byte
// WR_DATA | address latched, waiting for the data byte
// RD_ADDR | read opcode seen, waiting for the address byte
// RD_WAIT | RdEn issued, waiting for RdData_Valid or timeout
// TX_SEND | holding read byte until UART TX is free
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter logic [DATA_W-1:0] WR_CMD     = WR_CMD_DEF,
  parameter logic [DATA_W-1:0] RD_CMD     = RD_CMD_DEF,
  parameter int                RD_TIMEOUT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_Data,
  input  logic              RX_D_VLD,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdData_Valid,
  input  logic              TX_Busy,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic [DATA_W-1:0] WrData,
  output logic              RdEn,
  output logic [DATA_W-1:0] TX_P_Data,
  output logic              TX_D_VLD,
  output logic              Busy,
  output logic              Cmd_Err,
  output logic              Rd_Timeout,
  output logic              Rx_Drop
);

  localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_address;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_rd_en;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_vld;
  logic              r_busy;
  logic              r_cmd_err;
  logic              r_rd_to;
  logic              r_rx_drop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wr_addr <= '0;
      r_rd_data <= '0;
      r_address <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_rd_en   <= 1'b0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_rd_to   <= 1'b0;
      r_rx_drop <= 1'b0;
    end else begin
      // Strobes and error flags are single-cycle by construction.
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_cmd_err <= 1'b0;
      r_rd_to   <= 1'b0;
      r_rx_drop <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_Data == WR_CMD) begin
              r_state <= ST_WR_ADDR;
              r_busy  <= 1'b1;
            end else if (RX_P_Data == RD_CMD) begin
              r_state <= ST_RD_ADDR;
              r_busy  <= 1'b1;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        end

        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            r_wr_addr <= RX_P_Data[ADDR_W-1:0];
            r_state   <= ST_WR_DATA;
          end
        end

        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            r_wr_en   <= 1'b1;
            r_address <= r_wr_addr;
            r_wr_data <= RX_P_Data;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end
        end

        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            r_rd_en   <= 1'b1;
            r_address <= RX_P_Data[ADDR_W-1:0];
            r_cnt     <= '0;
            r_state   <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          r_rx_drop <= RX_D_VLD;
          if (RdData_Valid) begin
            r_rd_data <= RdData;
            r_state   <= ST_TX_SEND;
          end else if (r_cnt == CNT_LAST) begin
            r_rd_to <= 1'b1;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_TX_SEND: begin
          r_rx_drop <= RX_D_VLD;
          if (!TX_Busy) begin
            r_tx_data <= r_rd_data;
            r_tx_vld  <= 1'b1;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Address    = r_address;
  assign WrEn       = r_wr_en;
  assign WrData     = r_wr_data;
  assign RdEn       = r_rd_en;
  assign TX_P_Data  = r_tx_data;
  assign TX_D_VLD   = r_tx_vld;
  assign Busy       = r_busy;
  assign Cmd_Err    = r_cmd_err;
  assign Rd_Timeout = r_rd_to;
  assign Rx_Drop    = r_rx_drop;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl with a small register-file responder model.
module tb_reg_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_Data;
  logic       RX_D_VLD;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       TX_Busy;
  logic [3:0] Address;
  logic       WrEn;
  logic [7:0] WrData;
  logic       RdEn;
  logic [7:0] TX_P_Data;
  logic       TX_D_VLD;
  logic       Busy;
  logic       Cmd_Err;
  logic       Rd_Timeout;
  logic       Rx_Drop;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int tx_cnt = 0;
  int snap;
  bit rf_en = 1'b1;
  logic [7:0] mem [16];
  bit         got;
  logic [7:0] dat;

  always #5 CLK = ~CLK;

  reg_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_Busy(TX_Busy),
    .Address(Address), .WrEn(WrEn), .WrData(WrData), .RdEn(RdEn),
    .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD), .Busy(Busy),
    .Cmd_Err(Cmd_Err), .Rd_Timeout(Rd_Timeout), .Rx_Drop(Rx_Drop)
  );

  // Register-file responder: one-cycle read latency, writes on WrEn.
  always @(posedge CLK) begin
    if (WrEn) mem[Address] <= WrData;
    RdData_Valid <= RdEn && rf_en;
    RdData       <= mem[Address];
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (WrEn) wr_cnt++;
      if (TX_D_VLD) tx_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_Data = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int limit, output bit seen, output logic [7:0] d);
    seen = 1'b0;
    d    = '0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (TX_D_VLD) begin
        seen = 1'b1;
        d    = TX_P_Data;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[2] = 8'h21;
    mem[3] = 8'h08;
    RST = 1'b1; RX_P_Data = '0; RX_D_VLD = 1'b0; TX_Busy = 1'b0;
    RdData = '0; RdData_Valid = 1'b0;
    tick(2);
    check("rst_outputs", 32'({Address, WrEn, WrData, RdEn, TX_P_Data, TX_D_VLD,
                              Busy, Cmd_Err, Rd_Timeout, Rx_Drop}), 32'd0);
    RST = 1'b0;
    tick();

    // Read after reset: addr 2 -> 21
    send_byte(8'hBB);
    check("rd2_busy", 32'(Busy), 32'd1);
    tick(3);
    send_byte(8'h02);
    check("rd2_rden", 32'(RdEn), 32'd1);
    check("rd2_addr", 32'(Address), 32'd2);
    check("rd2_wren_low", 32'(WrEn), 32'd0);
    tick();
    check("rd2_rden_pulse", 32'(RdEn), 32'd0);
    tick();
    tick();
    check("rd2_txvld", 32'(TX_D_VLD), 32'd1);
    check("rd2_txdata", 32'(TX_P_Data), 32'h21);
    tick();
    check("rd2_txvld_pulse", 32'(TX_D_VLD), 32'd0);
    check("rd2_busy_done", 32'(Busy), 32'd0);
    check("rd2_txdata_hold", 32'(TX_P_Data), 32'h21);

    // Write AA,05,3C then read it back
    send_byte(8'hAA); tick(3);
    send_byte(8'h05); tick(3);
    send_byte(8'h3C);
    check("wr5_wren", 32'(WrEn), 32'd1);
    check("wr5_addr", 32'(Address), 32'd5);
    check("wr5_data", 32'(WrData), 32'h3C);
    check("wr5_rden_low", 32'(RdEn), 32'd0);
    tick();
    check("wr5_wren_pulse", 32'(WrEn), 32'd0);
    check("wr5_addr_hold", 32'(Address), 32'd5);
    send_byte(8'hBB);
    send_byte(8'h05);
    wait_tx(10, got, dat);
    check("rd5_tx_seen", 32'(got), 32'd1);
    check("rd5_tx_data", 32'(dat), 32'h3C);
    tick();

    // Back-pressure on TX with a dropped RX byte
    TX_Busy = 1'b1;
    snap = tx_cnt;
    send_byte(8'hBB);
    send_byte(8'h03);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        send_byte(8'h77);
        check("bp_rx_drop", 32'(Rx_Drop), 32'd1);
      end else begin
        tick();
      end
    end
    check("bp_no_tx", 32'(tx_cnt - snap), 32'd0);
    check("bp_busy", 32'(Busy), 32'd1);
    check("bp_drop_pulse", 32'(Rx_Drop), 32'd0);
    TX_Busy = 1'b0;
    tick();
    check("bp_txvld", 32'(TX_D_VLD), 32'd1);
    check("bp_txdata", 32'(TX_P_Data), 32'h08);
    tick();
    check("bp_idle", 32'(Busy), 32'd0);

    // Bad opcode, then address wrap
    send_byte(8'h5A);
    check("bad_cmd_err", 32'(Cmd_Err), 32'd1);
    check("bad_idle", 32'(Busy), 32'd0);
    tick();
    check("bad_cmd_err_pulse", 32'(Cmd_Err), 32'd0);
    send_byte(8'hAA);
    send_byte(8'hF7);
    send_byte(8'h99);
    check("wrap_wren", 32'(WrEn), 32'd1);
    check("wrap_addr", 32'(Address), 32'd7);
    check("wrap_data", 32'(WrData), 32'h99);
    tick();

    // Read timeout with no RdData_Valid
    rf_en = 1'b0;
    snap = tx_cnt;
    send_byte(8'hBB);
    send_byte(8'h01);
    check("to_rden", 32'(RdEn), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_early", 32'(Rd_Timeout), 32'd0);
    end
    tick();
    check("to_pulse", 32'(Rd_Timeout), 32'd1);
    check("to_idle", 32'(Busy), 32'd0);
    rf_en = 1'b1;
    send_byte(8'hAA);
    check("to_pulse_once", 32'(Rd_Timeout), 32'd0);
    send_byte(8'h0A);
    send_byte(8'h55);
    check("to_next_wren", 32'(WrEn), 32'd1);
    check("to_next_addr", 32'(Address), 32'hA);
    check("to_next_data", 32'(WrData), 32'h55);
    check("to_no_tx", 32'(tx_cnt - snap), 32'd0);
    tick();

    // Reset mid-frame
    send_byte(8'hAA);
    send_byte(8'h04);
    RST = 1'b1;
    tick();
    check("mid_rst_outputs", 32'({Address, WrEn, WrData, RdEn, TX_P_Data, TX_D_VLD,
                                  Busy, Cmd_Err, Rd_Timeout, Rx_Drop}), 32'd0);
    RST = 1'b0;
    send_byte(8'h11);
    check("mid_rst_cmd_err", 32'(Cmd_Err), 32'd1);
    check("mid_rst_no_wren", 32'(WrEn), 32'd0);
    tick(3);
    check("total_writes", 32'(wr_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
